// File: rtl/dsp_result_collector.sv
// Purpose: collects 34-bit DSP partial products, propagates carries, and emits 17-bit limbs LSB first.
// Latency: an accepted P word appears on word_o one cycle later when the output FIFO is empty.
// Backpressure: the DSP side is never stalled; P words arriving while the FIFO is full are dropped and overflow_o is set.
module dsp_result_collector #(
   parameter int WORD_COUNT = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [33:0] P_i,
   input  logic        P_valid_i,
   output logic [16:0] word_o,
   output logic        word_valid_o,
   output logic        word_last_o,
   input  logic        word_ready_i,
   output logic        busy_o,
   output logic        overflow_o
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(WORD_COUNT) + 1;
   localparam logic [CW-1:0] LAST_CNT  = CW'(WORD_COUNT - 1);
   localparam logic [AW:0]   FULL_OCC  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      FLUSH0 = 2'd2,
      FLUSH1 = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;

   // Operand accumulation state
   logic [17:0]     carry;
   logic [CW-1:0]   count;
   logic [34:0]     acc;
   logic            take_word;
   logic            op_clear;

   // Output FIFO: entries are {last, limb}
   logic [17:0]     fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     occ;
   logic            fifo_full;
   logic            fifo_empty;
   logic            push_req;
   logic            push;
   logic            pop;
   logic [17:0]     push_data;

   // P word plus the running carry; 35 bits cannot overflow for an 18-bit carry
   assign acc = {1'b0, P_i} + {17'b0, carry};

   assign fifo_full  = (occ == FULL_OCC);
   assign fifo_empty = (occ == '0);

   // Full check deliberately ignores a same-cycle pop to keep the push path shallow
   assign push = push_req & ~fifo_full;
   assign pop  = ~fifo_empty & word_ready_i;

   assign word_valid_o = ~fifo_empty;
   assign word_o       = fifo_mem[rd_ptr][16:0];
   assign word_last_o  = ~fifo_empty & fifo_mem[rd_ptr][17];
   assign busy_o       = (state != IDLE);

   // State register
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and FIFO push request per state
   always_comb begin
      state_nxt = state;
      push_req  = 1'b0;
      push_data = '0;
      take_word = 1'b0;
      op_clear  = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               op_clear  = 1'b1;
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            if (P_valid_i) begin
               take_word = 1'b1;
               push_req  = 1'b1;
               push_data = {1'b0, acc[16:0]};
               if (count == LAST_CNT) begin
                  state_nxt = FLUSH0;
               end
            end
         end
         FLUSH0: begin
            if (!fifo_full) begin
               push_req  = 1'b1;
               push_data = {1'b0, carry[16:0]};
               state_nxt = FLUSH1;
            end
         end
         FLUSH1: begin
            if (!fifo_full) begin
               push_req  = 1'b1;
               push_data = {1'b1, 16'b0, carry[17]};
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Carry, word count and sticky overflow; a dropped word still advances carry/count so framing holds
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         carry      <= '0;
         count      <= '0;
         overflow_o <= 1'b0;
      end else if (op_clear) begin
         carry      <= '0;
         count      <= '0;
         overflow_o <= 1'b0;
      end else if (take_word) begin
         carry <= acc[34:17];
         count <= count + CW'(1);
         if (fifo_full) begin
            overflow_o <= 1'b1;
         end
      end
   end

   // FIFO storage and write pointer; storage is cleared so word_o reads zero after reset
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wr_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
      end else if (push) begin
         fifo_mem[wr_ptr] <= push_data;
         wr_ptr           <= wr_ptr + AW'(1);
      end
   end

   // Read pointer; head entry is presented combinationally (first-word-fall-through)
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         rd_ptr <= '0;
      end else if (pop) begin
         rd_ptr <= rd_ptr + AW'(1);
      end
   end

   // Occupancy tracks push/pop; simultaneous push and pop leaves it unchanged
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         occ <= '0;
      end else begin
         case ({push, pop})
            2'b10:   occ <= occ + (AW + 1)'(1);
            2'b01:   occ <= occ - (AW + 1)'(1);
            default: occ <= occ;
         endcase
      end
   end

endmodule
